// File: rtl/cmos_ddr_pkg.sv
// cmos_ddr_pkg: shared widths, FSM encoding and DVP byte-pair to RGB565 helper for the capture writer.
package cmos_ddr_pkg;
    localparam int PIX_W        = 16;
    localparam int WORD_W       = 64;
    localparam int PIX_PER_WORD = 4;

    typedef enum logic [1:0] {WAIT_INIT, SKIP, ACTIVE} state_t;

    // b0 = R[4:0]G[5:3], b1 = G[2:0]B[4:0]; result is {B,G,R} as the display reader expects
    function automatic logic [PIX_W-1:0] rgb565_to_bgr(input logic [7:0] b0, input logic [7:0] b1);
        return {b1[4:0], b0[2:0], b1[7:5], b0[7:3]};
    endfunction
endpackage

// File: rtl/cmos_byte2pix.sv
// cmos_byte2pix: registers the DVP inputs, pairs bytes into RGB565 pixels and flags sync edges.
module cmos_byte2pix
    import cmos_ddr_pkg::*;
(
    input  logic             cmos_clk,
    input  logic             cmos_rst_n,
    input  logic             cmos_vsync,
    input  logic             cmos_href,
    input  logic [7:0]       cmos_data,
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix,
    output logic             vsync_rise,
    output logic             href_fall,
    output logic             href_act,
    output logic             phase_odd
);
    logic       vsync_q, vsync_prev_q, href_q, href_prev_q, phase_q, phase_d;
    logic [7:0] data_q, b0_q, b0_d;

    always_comb begin
        vsync_rise = vsync_q & ~vsync_prev_q;
        href_fall  = href_prev_q & ~href_q;
        phase_d    = href_q & ~phase_q & ~vsync_rise;
        b0_d       = (href_q & ~phase_q) ? data_q : b0_q;
        pix_valid  = href_q & phase_q;
        pix        = rgb565_to_bgr(b0_q, data_q);
    end

    assign href_act  = href_q;
    assign phase_odd = phase_q;

    always_ff @(posedge cmos_clk or negedge cmos_rst_n) begin
        if (!cmos_rst_n) begin
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            href_q       <= 1'b0;
            href_prev_q  <= 1'b0;
            data_q       <= 8'd0;
            phase_q      <= 1'b0;
            b0_q         <= 8'd0;
        end else begin
            vsync_q      <= cmos_vsync;
            vsync_prev_q <= vsync_q;
            href_q       <= cmos_href;
            href_prev_q  <= href_q;
            data_q       <= cmos_data;
            phase_q      <= phase_d;
            b0_q         <= b0_d;
        end
    end
endmodule

// File: rtl/cmos_ddr_pack.sv
// cmos_ddr_pack: packs camera RGB565 pixels four per 64-bit word into the DDR write FIFO,
// skipping the first frames after DDR init and flagging overflow and malformed lines.
module cmos_ddr_pack
    import cmos_ddr_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 10
) (
    input  logic              cmos_clk,
    input  logic              cmos_rst_n,
    input  logic              ddr_init_done,
    input  logic              cmos_vsync,
    input  logic              cmos_href,
    input  logic [7:0]        cmos_data,
    input  logic              ddr_wfull,
    output logic              ddr_wren,
    output logic [WORD_W-1:0] ddr_wdata,
    output logic              frame_start,
    output logic              frame_done,
    output logic              ovf_err,
    output logic              line_err
);
    localparam int LINE_W = $clog2(V_ACTIVE + 1);

    logic                  pix_valid, vsync_rise, href_fall, href_act, phase_odd, take;
    logic [PIX_W-1:0]      pix;
    state_t                state_q, state_d;
    logic [7:0]            skip_cnt_q, skip_cnt_d;
    logic [LINE_W-1:0]     line_cnt_q, line_cnt_d;
    logic [10:0]           pix_cnt_q, pix_cnt_d;
    logic [1:0]            slot_q, slot_d;
    logic [3*PIX_W-1:0]    acc_q, acc_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic                  wren_q, wren_d, last_q, last_d;
    logic                  frame_start_q, frame_start_d, frame_done_q, frame_done_d;
    logic                  ovf_err_q, ovf_err_d, line_err_q, line_err_d;

    cmos_byte2pix u_byte2pix (
        .cmos_clk   (cmos_clk),
        .cmos_rst_n (cmos_rst_n),
        .cmos_vsync (cmos_vsync),
        .cmos_href  (cmos_href),
        .cmos_data  (cmos_data),
        .pix_valid  (pix_valid),
        .pix        (pix),
        .vsync_rise (vsync_rise),
        .href_fall  (href_fall),
        .href_act   (href_act),
        .phase_odd  (phase_odd)
    );

    always_comb begin
        state_d       = state_q;
        skip_cnt_d    = skip_cnt_q;
        line_cnt_d    = line_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        slot_d        = slot_q;
        acc_d         = acc_q;
        wdata_d       = wdata_q;
        wren_d        = 1'b0;
        last_d        = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = last_q;
        ovf_err_d     = ovf_err_q | (wren_q & ddr_wfull);
        line_err_d    = line_err_q;
        take          = (state_q == ACTIVE) && pix_valid && (pix_cnt_q < 11'(H_ACTIVE))
                        && (line_cnt_q < LINE_W'(V_ACTIVE));
        if (!ddr_init_done) begin
            state_d    = WAIT_INIT;
            skip_cnt_d = '0;
            line_cnt_d = '0;
            pix_cnt_d  = '0;
            slot_d     = '0;
        end else if (state_q == WAIT_INIT) begin
            state_d = SKIP;
        end else if (state_q == SKIP) begin
            if (vsync_rise) begin
                state_d       = (skip_cnt_q >= 8'(SKIP_FRAMES)) ? ACTIVE : SKIP;
                frame_start_d = skip_cnt_q >= 8'(SKIP_FRAMES);
                skip_cnt_d    = skip_cnt_q + {7'd0, skip_cnt_q < 8'(SKIP_FRAMES)};
            end
        end else if (vsync_rise) begin
            // a vsync inside a line abandons whatever was half-packed
            frame_start_d = 1'b1;
            line_cnt_d    = '0;
            pix_cnt_d     = '0;
            slot_d        = '0;
            line_err_d    = line_err_q | href_act;
        end else if (href_fall) begin
            line_cnt_d = line_cnt_q + LINE_W'((pix_cnt_q != 11'd0) && (line_cnt_q < LINE_W'(V_ACTIVE)));
            pix_cnt_d  = '0;
            slot_d     = '0;
            line_err_d = line_err_q | (slot_q != 2'd0) | phase_odd;
        end else if (pix_valid) begin
            pix_cnt_d = pix_cnt_q + {10'd0, pix_cnt_q != 11'h7FF};
            if (take) begin
                slot_d  = slot_q + 2'd1;
                acc_d   = (slot_q == 2'd0) ? {pix, acc_q[31:0]} :
                          (slot_q == 2'd1) ? {acc_q[47:32], pix, acc_q[15:0]} :
                                             {acc_q[47:16], pix};
                wren_d  = slot_q == 2'd3;
                wdata_d = (slot_q == 2'd3) ? {acc_q, pix} : wdata_q;
                last_d  = (slot_q == 2'd3) && (line_cnt_q == LINE_W'(V_ACTIVE - 1))
                          && (pix_cnt_q == 11'(H_ACTIVE - 1));
            end
        end
    end

    always_ff @(posedge cmos_clk or negedge cmos_rst_n) begin
        if (!cmos_rst_n) begin
            state_q       <= WAIT_INIT;
            skip_cnt_q    <= '0;
            line_cnt_q    <= '0;
            pix_cnt_q     <= '0;
            slot_q        <= '0;
            acc_q         <= '0;
            wdata_q       <= '0;
            wren_q        <= 1'b0;
            last_q        <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            ovf_err_q     <= 1'b0;
            line_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            skip_cnt_q    <= skip_cnt_d;
            line_cnt_q    <= line_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            slot_q        <= slot_d;
            acc_q         <= acc_d;
            wdata_q       <= wdata_d;
            wren_q        <= wren_d;
            last_q        <= last_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            ovf_err_q     <= ovf_err_d;
            line_err_q    <= line_err_d;
        end
    end

    // a full FIFO in the strobe cycle swallows the word; packing carries on
    assign ddr_wren    = wren_q & ~ddr_wfull;
    assign ddr_wdata   = wdata_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign ovf_err     = ovf_err_q;
    assign line_err    = line_err_q;
endmodule

// File: tb/tb_cmos_ddr_pack.sv
// tb_cmos_ddr_pack: directed bench for the DVP-to-DDR packer, run with a short frame
// (V_ACTIVE=4) and two skipped frames so every scenario fits in a few thousand cycles.
module tb_cmos_ddr_pack;
    localparam int H = 640;
    localparam int V = 4;

    logic        cmos_clk = 1'b0;
    logic        cmos_rst_n, ddr_init_done, cmos_vsync, cmos_href, ddr_wfull;
    logic [7:0]  cmos_data;
    logic        ddr_wren, frame_start, frame_done, ovf_err, line_err;
    logic [63:0] ddr_wdata;
    logic [63:0] words[$];
    int checks = 0, errors = 0, cyc = 0, wr_cyc = 0, n_fs = 0, n_fd = 0;

    cmos_ddr_pack #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(2)) dut (
        .cmos_clk      (cmos_clk),
        .cmos_rst_n    (cmos_rst_n),
        .ddr_init_done (ddr_init_done),
        .cmos_vsync    (cmos_vsync),
        .cmos_href     (cmos_href),
        .cmos_data     (cmos_data),
        .ddr_wfull     (ddr_wfull),
        .ddr_wren      (ddr_wren),
        .ddr_wdata     (ddr_wdata),
        .frame_start   (frame_start),
        .frame_done    (frame_done),
        .ovf_err       (ovf_err),
        .line_err      (line_err)
    );

    always #5 cmos_clk = ~cmos_clk;
    always @(posedge cmos_clk) cyc <= cyc + 1;
    always @(negedge cmos_clk) begin
        if (ddr_wren) begin
            words.push_back(ddr_wdata);
            wr_cyc <= cyc;
        end
        if (frame_start) n_fs <= n_fs + 1;
        if (frame_done) n_fd <= n_fd + 1;
    end

    function automatic logic [15:0] pv(input int s, input int i);
        return 16'(s * 4099 + i * 7);
    endfunction

    // inverse of the sensor byte order: byte0 = R,G[5:3]; byte1 = G[2:0],B
    function automatic logic [7:0] pbyte(input int s, input int bi);
        logic [15:0] v;
        v = pv(s, bi / 2);
        return bi[0] ? {v[7:5], v[15:11]} : {v[4:0], v[10:8]};
    endfunction

    function automatic logic [63:0] ew(input int s, input int w);
        return {pv(s, 4 * w), pv(s, 4 * w + 1), pv(s, 4 * w + 2), pv(s, 4 * w + 3)};
    endfunction

    task automatic tick();
        @(posedge cmos_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic put_byte(input logic [7:0] b);
        cmos_href = 1'b1;
        cmos_data = b;
        tick();
    endtask

    task automatic end_line();
        cmos_href = 1'b0;
        ddr_wfull = 1'b0;
        cmos_data = 8'h00;
        idle(8);
    endtask

    task automatic send_pixels(input int n, input int s, input int wf_lo = -1, input int wf_hi = -1);
        for (int bi = 0; bi < 2 * n; bi++) begin
            ddr_wfull = (bi >= wf_lo) && (bi <= wf_hi);
            put_byte(pbyte(s, bi));
        end
        end_line();
    endtask

    task automatic vsync_pulse();
        cmos_vsync = 1'b1;
        idle(3);
        cmos_vsync = 1'b0;
        idle(3);
    endtask

    task automatic test_reset();
        cmos_rst_n = 1'b0; ddr_init_done = 1'b0; cmos_vsync = 1'b0;
        cmos_href = 1'b0; cmos_data = 8'h00; ddr_wfull = 1'b0;
        idle(3);
        checks++; if (ddr_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b want 0", ddr_wren); end
        checks++; if (ddr_wdata !== 64'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", ddr_wdata); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", frame_start); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", frame_done); end
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf_err); end
        checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL reset_lerr: got %b want 0", line_err); end
        cmos_rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_skip();
        int fs0;
        ddr_init_done = 1'b1;
        idle(3);
        words.delete();
        fs0 = n_fs;
        for (int f = 1; f <= 2; f++) begin
            vsync_pulse();
            send_pixels(8, f);
        end
        checks++; if (words.size() != 0) begin errors++; $display("FAIL skip_no_strobe: got %0d want 0", words.size()); end
        checks++; if (n_fs != fs0) begin errors++; $display("FAIL skip_no_fs: got %0d want %0d", n_fs, fs0); end
        vsync_pulse();
        checks++; if (n_fs != fs0 + 1) begin errors++; $display("FAIL skip_fs3: got %0d want %0d", n_fs, fs0 + 1); end
        send_pixels(8, 3);
        vsync_pulse();
        checks++; if (n_fs != fs0 + 2) begin errors++; $display("FAIL skip_fs4: got %0d want %0d", n_fs, fs0 + 2); end
        send_pixels(8, 4);
        checks++; if (words.size() != 4) begin errors++; $display("FAIL skip_count: got %0d want 4", words.size()); end
        checks++; if (words[0] !== ew(3, 0)) begin errors++; $display("FAIL skip_f3w0: got %h want %h", words[0], ew(3, 0)); end
        checks++; if (words[3] !== ew(4, 1)) begin errors++; $display("FAIL skip_f4w1: got %h want %h", words[3], ew(4, 1)); end
    endtask

    task automatic test_basic();
        logic [7:0] bb[8] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
        int fs0, d;
        vsync_pulse();
        words.delete();
        fs0 = n_fs;
        for (int k = 0; k < 7; k++) put_byte(bb[k]);
        d = cyc;
        put_byte(bb[7]);
        end_line();
        checks++; if (n_fs != fs0) begin errors++; $display("FAIL basic_fs_extra: got %0d want %0d", n_fs, fs0); end
        checks++; if (words.size() != 1) begin errors++; $display("FAIL basic_count: got %0d want 1", words.size()); end
        checks++; if (words[0] !== 64'h001F_07E0_F800_FFFF) begin errors++; $display("FAIL basic_word: got %h want 001f07e0f800ffff", words[0]); end
        checks++; if (wr_cyc != d + 2) begin errors++; $display("FAIL basic_latency: got %0d want %0d", wr_cyc - d, 2); end
    endtask

    task automatic test_full_frame();
        int fd0, bad;
        vsync_pulse();
        words.delete();
        fd0 = n_fd;
        bad = 0;
        for (int l = 0; l < V + 1; l++) send_pixels(H, 16 + l);
        for (int w = 0; w < words.size() && w < V * H / 4; w++)
            if (words[w] !== ew(16 + w / (H / 4), w % (H / 4))) bad++;
        checks++; if (words.size() != V * H / 4) begin errors++; $display("FAIL frame_count: got %0d want %0d", words.size(), V * H / 4); end
        checks++; if (bad != 0) begin errors++; $display("FAIL frame_order: got %0d bad words want 0", bad); end
        checks++; if (n_fd != fd0 + 1) begin errors++; $display("FAIL frame_done: got %0d pulses want 1", n_fd - fd0); end
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL frame_ovf: got %b want 0", ovf_err); end
        checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL frame_lerr: got %b want 0", line_err); end
    endtask

    task automatic test_overflow();
        vsync_pulse();
        words.delete();
        send_pixels(32, 5, 38, 44);
        checks++; if (words.size() != 7) begin errors++; $display("FAIL ovf_count: got %0d want 7", words.size()); end
        checks++; if (words[3] !== ew(5, 3)) begin errors++; $display("FAIL ovf_w4: got %h want %h", words[3], ew(5, 3)); end
        checks++; if (words[4] !== ew(5, 5)) begin errors++; $display("FAIL ovf_w6: got %h want %h", words[4], ew(5, 5)); end
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf_err); end
        checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL ovf_lerr: got %b want 0", line_err); end
    endtask

    task automatic test_short_line();
        vsync_pulse();
        words.delete();
        send_pixels(6, 6);
        checks++; if (words.size() != 1) begin errors++; $display("FAIL short_count: got %0d want 1", words.size()); end
        checks++; if (words[0] !== ew(6, 0)) begin errors++; $display("FAIL short_word: got %h want %h", words[0], ew(6, 0)); end
        checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL short_lerr: got %b want 1", line_err); end
        send_pixels(8, 7);
        checks++; if (words[1] !== ew(7, 0)) begin errors++; $display("FAIL short_next0: got %h want %h", words[1], ew(7, 0)); end
        checks++; if (words[2] !== ew(7, 1)) begin errors++; $display("FAIL short_next1: got %h want %h", words[2], ew(7, 1)); end
        words.delete();
        send_pixels(700, 8);
        checks++; if (words.size() != 160) begin errors++; $display("FAIL long_count: got %0d want 160", words.size()); end
        checks++; if (words[159] !== ew(8, 159)) begin errors++; $display("FAIL long_last: got %h want %h", words[159], ew(8, 159)); end
    endtask

    task automatic test_resets();
        int fs0;
        vsync_pulse();
        words.delete();
        for (int bi = 0; bi < 5; bi++) put_byte(pbyte(9, bi));
        cmos_rst_n = 1'b0;
        #2;
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf_err); end
        checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL rst_lerr: got %b want 0", line_err); end
        checks++; if (ddr_wren !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b want 0", ddr_wren); end
        tick();
        put_byte(pbyte(9, 5));
        cmos_rst_n = 1'b1;
        for (int bi = 6; bi < 16; bi++) put_byte(pbyte(9, bi));
        end_line();
        checks++; if (words.size() != 0) begin errors++; $display("FAIL rst_stray: got %0d strobes want 0", words.size()); end
        for (int f = 0; f < 3; f++) vsync_pulse();
        fs0 = n_fs;
        for (int bi = 0; bi < 16; bi++) begin
            ddr_init_done = !(bi == 5 || bi == 6);
            put_byte(pbyte(10, bi));
        end
        end_line();
        checks++; if (words.size() != 0) begin errors++; $display("FAIL init_stray: got %0d strobes want 0", words.size()); end
        checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL init_lerr: got %b want 0", line_err); end
        vsync_pulse();
        checks++; if (n_fs != fs0) begin errors++; $display("FAIL init_skip_fs: got %0d want %0d", n_fs, fs0); end
        vsync_pulse();
        vsync_pulse();
        checks++; if (n_fs != fs0 + 1) begin errors++; $display("FAIL init_fs: got %0d want %0d", n_fs, fs0 + 1); end
        send_pixels(8, 11);
        checks++; if (words.size() != 2) begin errors++; $display("FAIL init_count: got %0d want 2", words.size()); end
        checks++; if (words[1] !== ew(11, 1)) begin errors++; $display("FAIL init_word: got %h want %h", words[1], ew(11, 1)); end
    endtask

    initial begin
        test_reset();
        test_skip();
        test_basic();
        test_full_frame();
        test_overflow();
        test_short_line();
        test_resets();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmos_ddr_pack.md
Name: cmos_ddr_pack

Overview:
- Capture-side writer for the camera-to-DDR path, one instance per camera channel (ch0, ch1).
- Accepts 8-bit DVP bytes from an OV5640 and assembles RGB565 pixels.
- Packs 4 pixels into each 64-bit word and pushes the words into the DDR write FIFO.
- Word layout is exactly what the display reader unpacks: pixel 1 in [63:48], pixel 4 in [15:0]. Each pixel is {B[4:0],G[5:0],R[4:0]}.

Parameters:
- H_ACTIVE, 640: pixels written per line; extra pixels in a line are dropped.
- V_ACTIVE, 480: lines written per frame; extra lines are dropped.
- SKIP_FRAMES, 10: whole frames discarded after DDR init while sensor AE settles (0 = none).

Ports:
- cmos_clk  in  1  camera pixel clock; all logic on its rising edge.
- cmos_rst_n  in  1  asynchronous active-low reset.
- ddr_init_done  in  1  DDR calibration complete (already synchronised to cmos_clk).
- cmos_vsync  in  1  frame sync, active high; its rising edge marks a frame start.
- cmos_href  in  1  line valid, active high.
- cmos_data  in  8  DVP byte; RGB565 sent as byte0 = R[4:0]G[5:3], byte1 = G[2:0]B[4:0].
- ddr_wfull  in  1  DDR write FIFO full.
- ddr_wren  out  1  one-cycle write strobe.
- ddr_wdata  out  64  packed word, valid when ddr_wren=1.
- frame_start  out  1  one-cycle pulse; resets the DDR write address.
- frame_done  out  1  one-cycle pulse after the last word of a V_ACTIVE-line frame.
- ovf_err  out  1  sticky: a word was dropped because ddr_wfull=1.
- line_err  out  1  sticky: a line ended with a partial word or an odd byte count.

Behaviour:
- Reset values: all outputs 0; ddr_wdata 0; FSM in WAIT_INIT; all counters 0.
- Input stage: cmos_vsync, cmos_href and cmos_data are registered once. A vsync rising edge is detected from registered vs. previous-registered values.
- FSM states:
  - WAIT_INIT: move to SKIP when ddr_init_done=1.
  - SKIP: count vsync rising edges. When skip_cnt reaches SKIP_FRAMES, the next vsync rising edge enters ACTIVE. With SKIP_FRAMES=0, the first vsync rising edge enters ACTIVE.
  - ACTIVE: frame_start pulses 1 cycle after each detected vsync rise; line_cnt and pixel counters clear.
- ddr_init_done falling in any state returns the FSM to WAIT_INIT. The current partial word is discarded and no strobe is issued.
- Byte phase toggles on each registered href=1 byte and clears when href=0. Phase 0 captures the high byte; phase 1 forms pixel = {b1[4:0], b0[2:0], b1[7:5], b0[7:3]}.
- Pixel index pix_cnt is 11 bits. Pixels with pix_cnt >= H_ACTIVE, or on lines with line_cnt >= V_ACTIVE, are ignored.
- Packing: a 2-bit slot counter places the first pixel in [63:48], then [47:32], [31:16], [15:0].
- When the 4th pixel lands, ddr_wren=1 and ddr_wdata holds the word on the next cycle. Latency is 2 cycles from the port cycle carrying the 8th byte to the ddr_wren=1 cycle.
- FIFO full: if ddr_wfull=1 in the strobe cycle, the strobe is suppressed, ovf_err is set, and packing continues (the word is lost).
- href falling edge:
  - line_cnt increments if the line held at least 1 pixel.
  - If slot != 0 or the byte phase is odd, set line_err, discard the partial word, and reset slot and phase.
- frame_done pulses on the cycle after the last word of line V_ACTIVE-1 is strobed, or attempted when the FIFO is full.
- Vsync rise mid-line (href still high): the partial word is discarded, line_err is set, and the frame restarts with a frame_start pulse.
- Sticky flags clear only on reset.
- Counters saturate: line_cnt stops at V_ACTIVE; pix_cnt stops at 2047.

Decomposition:
- Shared package cmos_ddr_pkg:
  - localparams for PIX_W=16, WORD_W=64, PIX_PER_WORD=4.
  - FSM state encoding {WAIT_INIT, SKIP, ACTIVE}.
  - a function rgb565_to_bgr(b0, b1).
- One natural sub-module: cmos_byte2pix (input registers, byte phase, pixel assembly, href/vsync edge detect).
- The packer and FSM stay in cmos_ddr_pack.

Test Plan:
- Basic packing: ddr_init_done=1, SKIP_FRAMES=0, vsync pulse, then one line of 8 bytes 0xF8,0x00,0x07,0xE0,0x00,0x1F,0xFF,0xFF. Expect frame_start, then exactly 1 ddr_wren with ddr_wdata=64'h001F_07E0_F800_FFFF.
- Full frame: 640x480 ramp pixels. Expect 76800 strobes, correct word order, one frame_done, no error flags.
- Skip frames: SKIP_FRAMES=2, 4 frames sent. Expect no strobes during frames 1–2, frame_start on the 3rd vsync, and data from frames 3–4.
- FIFO overflow: hold ddr_wfull=1 across word 5 of a line. Expect that strobe absent, ovf_err=1, and word 6 correct.
- Short line: a line with 6 pixels. Expect 1 strobe, line_err=1, and the next line packing from slot 0. A 700-pixel line yields exactly 160 strobes.
- Resets: assert cmos_rst_n=0 mid-line, then ddr_init_done=0 mid-frame. Both outputs return to 0; the FSM waits for init and the next vsync, and no stray strobe appears.
